// File: rtl/out_gain_pkg.sv
`default_nettype none
//==============================================================================
// out_gain_pkg : shared widths, constants and saturation helper for out_gain
// Rev 1.0
//==============================================================================
package out_gain_pkg;

   localparam int SIG_W      = 16;
   localparam int GAIN_W     = 8;
   localparam int UNITY_GAIN = 1 << (GAIN_W - 1);
   localparam int MIDSCALE   = 1 << (SIG_W - 1);

   typedef logic [SIG_W-1:0]  sample_t;
   typedef logic [GAIN_W-1:0] gain_t;

   // Clamp a wide signed value into the signed SIG_W sample range.
   function automatic logic signed [SIG_W-1:0] sat_s(input logic signed [31:0] x);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = MIDSCALE - 1;
      lo = -MIDSCALE;
      if (x > hi)
         return hi[SIG_W-1:0];
      else if (x < lo)
         return lo[SIG_W-1:0];
      else
         return x[SIG_W-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/out_gain_gain_slew.sv
`default_nettype none
//==============================================================================
// gain_slew : moves cur_gain one LSB toward target per step (option: OUT_GAIN_ZC_EN)
// Rev 1.0
//==============================================================================
module gain_slew
   import out_gain_pkg::*;
#(
   parameter int GAIN_BITS  = GAIN_W,
   parameter int ZC_TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 step_en,
   input  logic [GAIN_BITS-1:0] target,
   input  logic                 sign,
   output logic [GAIN_BITS-1:0] cur_gain
);

   logic move;

`ifdef OUT_GAIN_ZC_EN
   localparam int CNT_W = (ZC_TIMEOUT > 1) ? $clog2(ZC_TIMEOUT) : 1;

   logic             prev_sign;
   logic [CNT_W-1:0] zc_cnt;

   // Step on a sign change, or when the sample count since the last step runs out.
   always_comb begin
      move = step_en && ((sign != prev_sign) || (zc_cnt == CNT_W'(ZC_TIMEOUT - 1)));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_sign <= 1'b0;
         zc_cnt    <= '0;
      end else if (step_en) begin
         prev_sign <= sign;
         zc_cnt    <= move ? '0 : zc_cnt + 1'b1;
      end
   end
`else
   always_comb begin
      move = step_en;
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cur_gain <= '0;
      else if (move && (cur_gain != target))
         cur_gain <= (cur_gain < target) ? cur_gain + 1'b1 : cur_gain - 1'b1;
   end

endmodule
`default_nettype wire

// File: rtl/out_gain.sv
`default_nettype none
//==============================================================================
// out_gain : output volume stage - gain slew, scale, saturate (option: OUT_GAIN_ZC_EN)
// Rev 1.0
//==============================================================================
module out_gain
   import out_gain_pkg::*;
#(
   parameter int SIG_BITS   = SIG_W,
   parameter int GAIN_BITS  = GAIN_W,
   parameter int ZC_TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [SIG_BITS-1:0]  in,
   input  logic                 in_valid,
   input  logic [GAIN_BITS-1:0] gain,
   output logic [SIG_BITS-1:0]  out,
   output logic                 out_valid,
   output logic [GAIN_BITS-1:0] cur_gain
);

   localparam int P_W = SIG_BITS + GAIN_BITS + 1;

   logic signed [SIG_BITS-1:0] centred;
   logic signed [SIG_BITS-1:0] d1;
   logic [GAIN_BITS-1:0]       g1;
   logic                       v1;
   logic signed [P_W-1:0]      p2;
   logic                       v2;
   logic signed [31:0]         q2;
   logic signed [SIG_BITS-1:0] sat2;

   assign centred = {~in[SIG_BITS-1], in[SIG_BITS-2:0]};

   gain_slew #(
      .GAIN_BITS  (GAIN_BITS),
      .ZC_TIMEOUT (ZC_TIMEOUT)
   ) u_slew (
      .clk      (clk),
      .reset_n  (reset_n),
      .step_en  (in_valid),
      .target   (gain),
      .sign     (centred[SIG_BITS-1]),
      .cur_gain (cur_gain)
   );

   // S1: centre the sample and latch the gain applied before this strobe's step.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         d1 <= '0;
         g1 <= '0;
         v1 <= 1'b0;
      end else begin
         v1 <= in_valid;
         if (in_valid) begin
            d1 <= centred;
            g1 <= cur_gain;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         p2 <= '0;
         v2 <= 1'b0;
      end else begin
         v2 <= v1;
         if (v1)
            p2 <= P_W'(d1) * P_W'($signed({1'b0, g1}));
      end
   end

   // Unity gain is 2^(GAIN_BITS-1); arithmetic shift floors toward -inf.
   assign q2   = 32'(p2) >>> (GAIN_BITS - 1);
   assign sat2 = sat_s(q2);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out       <= SIG_BITS'(MIDSCALE);
         out_valid <= 1'b0;
      end else begin
         out_valid <= v2;
         if (v2)
            out <= {~sat2[SIG_BITS-1], sat2[SIG_BITS-2:0]};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_out_gain.sv
`default_nettype none
//==============================================================================
// tb_out_gain : randomized self-checking bench for out_gain (option: OUT_GAIN_ZC_EN)
// Rev 1.0
//==============================================================================
module tb_out_gain;

   localparam int ZC_TIMEOUT = 1024;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] in = '0;
   logic        in_valid = 1'b0;
   logic [7:0]  gain = '0;
   logic [15:0] out;
   logic        out_valid;
   logic [7:0]  cur_gain;

   always #5 clk = ~clk;

   out_gain #(.SIG_BITS(16), .GAIN_BITS(8), .ZC_TIMEOUT(ZC_TIMEOUT)) dut (
      .clk(clk), .reset_n(reset_n), .in(in), .in_valid(in_valid), .gain(gain),
      .out(out), .out_valid(out_valid), .cur_gain(cur_gain)
   );

   int tests = 0;
   int failed = 0;
   int cyc = 0;
   int exp_q[$], exp_cyc[$], got_q[$], got_cyc[$];
   int m_gain = 0;
   int m_cnt = 0;
   bit m_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk)
      if (out_valid === 1'b1) begin
         got_q.push_back(int'(out));
         got_cyc.push_back(cyc);
      end

   // Reference: real-valued gain of m_gain/128 with floor, clipped to the sample range.
   function automatic void model_strobe(input int x, input int g);
      int d, q;
      bit step;
      d = x - 32768;
      q = (d * m_gain) >>> 7;
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
      exp_q.push_back(q + 32768);
      exp_cyc.push_back(cyc + 3);
`ifdef OUT_GAIN_ZC_EN
      step   = ((d < 0) != m_prev) || (m_cnt == ZC_TIMEOUT - 1);
      m_prev = (d < 0);
      m_cnt  = step ? 0 : m_cnt + 1;
`else
      step = 1'b1;
`endif
      if (step && g > m_gain) m_gain++;
      else if (step && g < m_gain) m_gain--;
   endfunction

   task automatic strobe(input int x, input int g);
      @(negedge clk);
      in = 16'(x);
      gain = 8'(g);
      in_valid = 1'b1;
      model_strobe(x, g);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (out !== 16'h8000) begin failed++; $display("FAIL reset_out: got %h want 8000", out); end
      tests++;
      if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      tests++;
      if (cur_gain !== 8'd0) begin failed++; $display("FAIL reset_gain: got %0d want 0", cur_gain); end
      in = 16'hC000; gain = 8'd128; in_valid = 1'b1;
      @(negedge clk);
      reset_n = 1'b1; in_valid = 1'b0;
      idle(6);
      tests++;
      if (got_q.size() != 0 || cur_gain !== 8'd0) begin
         failed++; $display("FAIL reset_release_ignore: outputs=%0d gain=%0d want 0/0", got_q.size(), cur_gain);
      end
      got_q.delete(); got_cyc.delete();
   endtask

   task automatic test_fade_in();
      int n;
      for (int i = 0; i < 140; i++) strobe(16'hC000, 128);
      idle(6);
      n = got_q.size();
      tests++;
      if (n != exp_q.size()) begin failed++; $display("FAIL fade_in count: got %0d want %0d", n, exp_q.size()); end
      for (int i = 0; i < n && i < exp_q.size(); i++) begin
         tests++;
         if (got_q[i] != exp_q[i] || got_cyc[i] != exp_cyc[i]) begin
            failed++; $display("FAIL fade_in[%0d]: got %h @%0d want %h @%0d", i, got_q[i], got_cyc[i], exp_q[i], exp_cyc[i]);
         end
      end
      tests++;
      if (n < 140 || got_q[0] != 32'h8000 || got_q[139] != 32'hC000) begin
         failed++; $display("FAIL fade_in_ends: first %h last %h want 8000/C000", n > 0 ? got_q[0] : -1, n > 0 ? got_q[n-1] : -1);
      end
      tests++;
      if (cur_gain !== 8'd128) begin failed++; $display("FAIL fade_in_gain: got %0d want 128", cur_gain); end
      got_q.delete(); got_cyc.delete(); exp_q.delete(); exp_cyc.delete();
   endtask

   task automatic test_gain_255();
      int n;
      for (int i = 0; i < 130; i++) strobe($urandom_range(0, 65535), 255);
      strobe(16'hFFFF, 255); strobe(16'h0000, 255); strobe(16'h8000, 255);
      idle(6);
      n = got_q.size();
      tests++;
      if (n != exp_q.size()) begin failed++; $display("FAIL gain255 count: got %0d want %0d", n, exp_q.size()); end
      for (int i = 0; i < n && i < exp_q.size(); i++) begin
         tests++;
         if (got_q[i] != exp_q[i] || got_cyc[i] != exp_cyc[i]) begin
            failed++; $display("FAIL gain255[%0d]: got %h @%0d want %h @%0d", i, got_q[i], got_cyc[i], exp_q[i], exp_cyc[i]);
         end
      end
      tests++;
      if (n != 133 || got_q[130] != 32'hFFFF || got_q[131] != 32'h0000 || got_q[132] != 32'h8000) begin
         failed++; $display("FAIL gain255_sat: tail %h %h %h want FFFF 0000 8000",
                            n > 2 ? got_q[n-3] : -1, n > 1 ? got_q[n-2] : -1, n > 0 ? got_q[n-1] : -1);
      end
      got_q.delete(); got_cyc.delete(); exp_q.delete(); exp_cyc.delete();
   endtask

   task automatic test_gain_64();
      int n;
      for (int i = 0; i < 200; i++) strobe($urandom_range(0, 65535), 64);
      strobe(16'h9000, 64); strobe(16'h7FFF, 64);
      idle(6);
      n = got_q.size();
      tests++;
      if (n != exp_q.size()) begin failed++; $display("FAIL gain64 count: got %0d want %0d", n, exp_q.size()); end
      for (int i = 0; i < n && i < exp_q.size(); i++) begin
         tests++;
         if (got_q[i] != exp_q[i] || got_cyc[i] != exp_cyc[i]) begin
            failed++; $display("FAIL gain64[%0d]: got %h @%0d want %h @%0d", i, got_q[i], got_cyc[i], exp_q[i], exp_cyc[i]);
         end
      end
      tests++;
      if (n != 202 || got_q[200] != 32'h8800 || got_q[201] != 32'h7FFF) begin
         failed++; $display("FAIL gain64_half: tail %h %h want 8800 7FFF",
                            n > 1 ? got_q[n-2] : -1, n > 0 ? got_q[n-1] : -1);
      end
      got_q.delete(); got_cyc.delete(); exp_q.delete(); exp_cyc.delete();
   endtask

   task automatic test_slew_down();
      int n, want;
      for (int i = 0; i < 70; i++) strobe($urandom_range(0, 65535), 128);
      idle(1);
      tests++;
      if (cur_gain !== 8'd128) begin failed++; $display("FAIL slew_settle: got %0d want 128", cur_gain); end
      for (int i = 0; i < 40; i++) begin
         strobe($urandom_range(0, 65535), 100);
         want = (128 - i < 100) ? 100 : 128 - i;
         tests++;
         if (cur_gain !== 8'(want)) begin failed++; $display("FAIL slew_step[%0d]: got %0d want %0d", i, cur_gain, want); end
      end
      idle(6);
      n = got_q.size();
      tests++;
      if (n != exp_q.size()) begin failed++; $display("FAIL slew count: got %0d want %0d", n, exp_q.size()); end
      for (int i = 0; i < n && i < exp_q.size(); i++) begin
         tests++;
         if (got_q[i] != exp_q[i] || got_cyc[i] != exp_cyc[i]) begin
            failed++; $display("FAIL slew[%0d]: got %h @%0d want %h @%0d", i, got_q[i], got_cyc[i], exp_q[i], exp_cyc[i]);
         end
      end
      tests++;
      if (cur_gain !== 8'd100) begin failed++; $display("FAIL slew_final: got %0d want 100", cur_gain); end
      got_q.delete(); got_cyc.delete(); exp_q.delete(); exp_cyc.delete();
   endtask

`ifdef OUT_GAIN_ZC_EN
   task automatic test_zc();
      int n;
      for (int i = 0; i < ZC_TIMEOUT; i++) strobe(16'hA000, 128);
      idle(1);
      tests++;
      if (cur_gain !== 8'd1) begin failed++; $display("FAIL zc_timeout: got %0d want 1", cur_gain); end
      for (int i = 0; i < 10; i++) strobe((i % 2 == 0) ? 16'h6000 : 16'hA000, 128);
      idle(6);
      tests++;
      if (cur_gain !== 8'd11) begin failed++; $display("FAIL zc_alternate: got %0d want 11", cur_gain); end
      n = got_q.size();
      tests++;
      if (n != exp_q.size()) begin failed++; $display("FAIL zc count: got %0d want %0d", n, exp_q.size()); end
      for (int i = 0; i < n && i < exp_q.size(); i++) begin
         tests++;
         if (got_q[i] != exp_q[i] || got_cyc[i] != exp_cyc[i]) begin
            failed++; $display("FAIL zc[%0d]: got %h @%0d want %h @%0d", i, got_q[i], got_cyc[i], exp_q[i], exp_cyc[i]);
         end
      end
      got_q.delete(); got_cyc.delete(); exp_q.delete(); exp_cyc.delete();
   endtask
`endif

   task automatic test_reset_midstream();
      int n;
      for (int i = 0; i < 5; i++) strobe(16'hC000, 100);
      idle(6);
      got_q.delete(); got_cyc.delete(); exp_q.delete(); exp_cyc.delete();
      strobe(16'hC000, 100); strobe(16'hC000, 100);
      @(negedge clk);
      in_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      tests++;
      if (out !== 16'h8000 || cur_gain !== 8'd0 || out_valid !== 1'b0) begin
         failed++; $display("FAIL midreset_async: out=%h gain=%0d valid=%b want 8000/0/0", out, cur_gain, out_valid);
      end
      exp_q.delete(); exp_cyc.delete();
      m_gain = 0; m_cnt = 0; m_prev = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      idle(4);
      tests++;
      if (got_q.size() != 0) begin failed++; $display("FAIL midreset_discard: got %0d outputs want 0", got_q.size()); end
      got_q.delete(); got_cyc.delete();
      for (int i = 0; i < 3; i++) strobe(16'hC000, 128);
      idle(6);
      n = got_q.size();
      tests++;
      if (n != exp_q.size()) begin failed++; $display("FAIL midreset count: got %0d want %0d", n, exp_q.size()); end
      for (int i = 0; i < n && i < exp_q.size(); i++) begin
         tests++;
         if (got_q[i] != exp_q[i] || got_cyc[i] != exp_cyc[i]) begin
            failed++; $display("FAIL midreset[%0d]: got %h @%0d want %h @%0d", i, got_q[i], got_cyc[i], exp_q[i], exp_cyc[i]);
         end
      end
      tests++;
      if (n < 1 || got_q[0] != 32'h8000) begin failed++; $display("FAIL midreset_first: got %h want 8000", n > 0 ? got_q[0] : -1); end
      got_q.delete(); got_cyc.delete(); exp_q.delete(); exp_cyc.delete();
   endtask

   task automatic test_back_to_back();
      int n, tgt;
      tgt = $urandom_range(0, 255);
      for (int i = 0; i < 400; i++) begin
         if (i % 50 == 0) tgt = $urandom_range(0, 255);
         if ($urandom_range(0, 9) < 7) begin
            strobe($urandom_range(0, 65535), tgt);
         end else begin
            @(negedge clk);
            in_valid = 1'b0;
            gain = 8'($urandom_range(0, 255));
         end
      end
      idle(6);
      tests++;
      if (cur_gain !== 8'(m_gain)) begin failed++; $display("FAIL b2b_gain: got %0d want %0d", cur_gain, m_gain); end
      n = got_q.size();
      tests++;
      if (n != exp_q.size()) begin failed++; $display("FAIL b2b count: got %0d want %0d", n, exp_q.size()); end
      for (int i = 0; i < n && i < exp_q.size(); i++) begin
         tests++;
         if (got_q[i] != exp_q[i] || got_cyc[i] != exp_cyc[i]) begin
            failed++; $display("FAIL b2b[%0d]: got %h @%0d want %h @%0d", i, got_q[i], got_cyc[i], exp_q[i], exp_cyc[i]);
         end
      end
      got_q.delete(); got_cyc.delete(); exp_q.delete(); exp_cyc.delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
`ifdef OUT_GAIN_ZC_EN
      test_zc();
`else
      test_fade_in();
      test_gain_255();
      test_gain_64();
      test_slew_down();
`endif
      test_reset_midstream();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
